// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback select, load extraction and register-file write port with load-timeout flag
module wb_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [1:0]  ex_wb_sel_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_alu_res_i,
    input  logic [31:0] ex_pc4_i,
    input  logic [2:0]  ex_ld_fmt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        err_clr_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    localparam logic [1:0] SEL_NONE = 2'b00, SEL_MEM = 2'b10, SEL_PC4 = 2'b11;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  rd_q;
    logic [2:0]  fmt_q;
    logic [1:0]  off_q;
    logic        rf_we_q, err_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] ld_data_d;
    always_comb begin
        byte_d    = mem_rdata_i[8*off_q +: 8];
        half_d    = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ld_data_d = fmt_q == 3'b000 ? {{24{byte_d[7]}}, byte_d} :
                    fmt_q == 3'b100 ? {24'h0, byte_d} :
                    fmt_q == 3'b001 ? {{16{half_d[15]}}, half_d} :
                    fmt_q == 3'b101 ? {16'h0, half_d} : mem_rdata_i;
    end
    // the timeout edge is the one on which the incremented count would reach TIMEOUT-1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            rd_q       <= 5'd0;
            fmt_q      <= 3'd0;
            off_q      <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            if (err_clr_i) err_q <= 1'b0;
            if (state_q == IDLE) begin
                if (ex_valid_i && ex_wb_sel_i == SEL_MEM) begin
                    rd_q    <= ex_rd_addr_i;
                    fmt_q   <= ex_ld_fmt_i;
                    off_q   <= ex_alu_res_i[1:0];
                    cnt_q   <= 8'd0;
                    state_q <= WAIT_MEM;
                end else if (ex_valid_i && ex_wb_sel_i != SEL_NONE) begin
                    rf_we_q    <= |ex_rd_addr_i;
                    rf_waddr_q <= ex_rd_addr_i;
                    rf_wdata_q <= ex_wb_sel_i == SEL_PC4 ? ex_pc4_i : ex_alu_res_i;
                end
            end else if (mem_rvalid_i) begin
                rf_we_q    <= |rd_q;
                rf_waddr_q <= rd_q;
                rf_wdata_q <= ld_data_d;
                state_q    <= IDLE;
            end else if (cnt_q == 8'(TIMEOUT - 2)) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end
    assign ex_ready_o = state_q == IDLE;
    assign busy_o     = state_q == WAIT_MEM;
    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: scoreboard bench for wb_ctrl writes, load extraction, timeout and reset
module tb_wb_ctrl;
    logic        clk = 0, rst = 1, ex_valid = 0, mem_rvalid = 0, err_clr = 0;
    logic [1:0]  wb_sel = 0;
    logic [4:0]  rd_addr = 0;
    logic [31:0] alu_res = 0, pc4 = 0, mem_rdata = 0;
    logic [2:0]  ld_fmt = 0;
    logic        ex_ready, rf_we, busy, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    int checks = 0, errors = 0;
    logic [36:0] sbq[$];

    wb_ctrl #(.TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
        .ex_wb_sel_i(wb_sel), .ex_rd_addr_i(rd_addr), .ex_alu_res_i(alu_res),
        .ex_pc4_i(pc4), .ex_ld_fmt_i(ld_fmt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .err_clr_i(err_clr), .rf_we_o(rf_we),
        .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // every write pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", rf_waddr, rf_wdata);
            end else begin
                logic [36:0] exp;
                exp = sbq.pop_front();
                if ({rf_waddr, rf_wdata} !== exp) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                             rf_waddr, rf_wdata, exp[36:32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic accept(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] p4, input logic [2:0] fmt);
        int n = 0;
        while (ex_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL accept_wait: ex_ready=%b, expected 1 within 50 cycles", ex_ready);
        end
        ex_valid = 1; wb_sel = sel; rd_addr = rd; alu_res = alu; pc4 = p4; ld_fmt = fmt;
        if ((sel == 2'b01 || sel == 2'b11) && rd != 0) sbq.push_back({rd, sel == 2'b11 ? p4 : alu});
        @(posedge clk); #1;
        ex_valid = 0;
    endtask

    task automatic do_load(input logic [2:0] fmt, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int delay, input logic [31:0] exp);
        accept(2'b10, rd, addr, 32'h0, fmt);
        for (int i = 1; i <= delay; i++) begin
            if (i == delay) begin
                mem_rvalid = 1; mem_rdata = rdata;
                if (rd != 0) sbq.push_back({rd, exp});
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || ex_ready !== 1'b0) begin
                errors++;
                $display("FAIL load_busy cycle %0d: busy=%b ex_ready=%b, expected 1/0", i, busy, ex_ready);
            end
            @(posedge clk); #1;
            mem_rvalid = 0; mem_rdata = $urandom;
        end
        @(negedge clk);
        checks++;
        if (rf_we !== (rd != 0) || ex_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done: we=%b ex_ready=%b busy=%b, expected %b/1/0", rf_we, ex_ready, busy, rd != 0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, busy, err, ex_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: we=%b addr=%0d data=%h busy=%b err=%b ready=%b, expected 0/0/0/0/0/1",
                     rf_we, rf_waddr, rf_wdata, busy, err, ex_ready);
        end
    endtask

    task automatic test_alu();
        accept(2'b01, 5'd5, 32'h12345678, 32'h0, 3'b0);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1) begin
            errors++; $display("FAIL alu_latency: we=%b, expected 1", rf_we);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL alu_pulse: we=%b, expected 0", rf_we);
        end
        accept(2'b11, 5'd31, 32'h0, 32'h00000200, 3'b0);
        accept(2'b00, 5'd4, 32'hABCD, 32'h0, 3'b0);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL sel_none: we=%b ready=%b, expected 0/1", rf_we, ex_ready);
        end
    endtask

    task automatic test_loads();
        do_load(3'b000, 32'h1003, 5'd7, 32'h80AABBCC, 3, 32'hFFFFFF80);
        do_load(3'b100, 32'h1003, 5'd7, 32'h80AABBCC, 3, 32'h00000080);
        do_load(3'b000, 32'h1000, 5'd8, 32'h80AABBCC, 1, 32'hFFFFFFCC);
        do_load(3'b100, 32'h1001, 5'd9, 32'h80AABBCC, 2, 32'h000000BB);
        do_load(3'b000, 32'h1002, 5'd10, 32'h80AABBCC, 1, 32'hFFFFFFAA);
        do_load(3'b001, 32'h2002, 5'd11, 32'h8001FFFF, 2, 32'hFFFF8001);
        do_load(3'b101, 32'h2000, 5'd12, 32'h8001FFFF, 1, 32'h0000FFFF);
        do_load(3'b001, 32'h2000, 5'd13, 32'h8001FFFF, 1, 32'hFFFFFFFF);
        do_load(3'b001, 32'h2003, 5'd14, 32'h8001FFFF, 1, 32'hFFFF8001);
        do_load(3'b101, 32'h2003, 5'd14, 32'h7FFF1234, 1, 32'h00007FFF);
        do_load(3'b010, 32'h3003, 5'd15, 32'hDEADBEEF, 4, 32'hDEADBEEF);
        do_load(3'b011, 32'h3001, 5'd16, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        do_load(3'b110, 32'h3002, 5'd17, 32'hCAFEF00D, 1, 32'hCAFEF00D);
        do_load(3'b000, 32'h3000, 5'd0, 32'h000000FF, 2, 32'h0);
    endtask

    task automatic test_back_to_back();
        accept(2'b11, 5'd0, 32'h0, 32'h104, 3'b0);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL x0_write: we=%b, expected 0", rf_we);
        end
        @(posedge clk); #1;
        ex_valid = 1; wb_sel = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            if (i <= 3) begin
                rd_addr = 5'(i); alu_res = 32'hA0 + i;
                sbq.push_back({5'(i), 32'hA0 + i});
            end else ex_valid = 0;
            @(posedge clk); #1;
            if (i == 3) ex_valid = 0;
            @(negedge clk);
            checks++;
            if (i <= 3 && (rf_we !== 1'b1 || rf_waddr !== 5'(i))) begin
                errors++; $display("FAIL back_to_back %0d: we=%b addr=%0d, expected 1/%0d", i, rf_we, rf_waddr, i);
            end else if (i == 4 && rf_we !== 1'b0) begin
                errors++; $display("FAIL back_to_back_end: we=%b, expected 0", rf_we);
            end
            if (i == 3) break;
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL back_to_back_end: we=%b, expected 0", rf_we);
        end
    endtask

    task automatic run_timeout(input logic clr_on_edge);
        accept(2'b10, 5'd9, 32'h4000, 32'h0, 3'b010);
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) err_clr = clr_on_edge;
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait cycle %0d: busy=%b err=%b, expected 1/0", i, busy, err);
            end
            @(posedge clk); #1;
            err_clr = 0;
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || ex_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: err=%b busy=%b ready=%b we=%b, expected 1/0/1/0", err, busy, ex_ready, rf_we);
        end
    endtask

    task automatic test_timeout();
        run_timeout(1'b0);
        mem_rvalid = 1; mem_rdata = 32'h55;
        @(posedge clk); #1 mem_rvalid = 0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL late_rvalid: we=%b err=%b, expected 0/1", rf_we, err);
        end
        accept(2'b01, 5'd6, 32'h66, 32'h0, 3'b0);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL err_no_block: we=%b err=%b, expected 1/1", rf_we, err);
        end
        err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clr: err=%b, expected 0", err);
        end
        do_load(3'b010, 32'h5000, 5'd20, 32'h13572468, 15, 32'h13572468);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL rvalid_at_limit: err=%b, expected 0", err);
        end
        run_timeout(1'b1);
    endtask

    task automatic test_reset_in_wait();
        accept(2'b10, 5'd21, 32'h6000, 32'h0, 3'b010);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, busy, err, ex_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_in_wait: we=%b addr=%0d data=%h busy=%b err=%b ready=%b, expected 0/0/0/0/0/1",
                     rf_we, rf_waddr, rf_wdata, busy, err, ex_ready);
        end
        mem_rvalid = 1; mem_rdata = 32'h77;
        @(posedge clk); #1 mem_rvalid = 0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL rvalid_after_reset: we=%b, expected 0", rf_we);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        repeat (2) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL missing_writes: %0d pending, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
